ram_burst_ctrl: RTL and testbench
=================================

// Module: ram_burst_ctrl
// PURPOSE
//  Parametrised single-port synchronous RAM with a cs/read/rdy command handshake, split data buses,
//  byte-enable writes and incrementing bursts of 1..2**BURST_W beats. Replaces the 16x16K tri-state RAM
//  as the processor/DMA data memory; one command in flight, rdy marks when the next is accepted.
// PARAMETERS
//  DATA_WIDTH   16     data bits per word; multiple of 8 (NB = DATA_WIDTH/8 byte lanes)
//  ADDR_WIDTH   16     address bus width
//  DEPTH        16384  words implemented; DEPTH <= 2**ADDR_WIDTH
//  BURST_W      4      burst length field width; beats = burst_len+1
// PORTS
//  clk        in   1           single clock, all logic on posedge
//  rst        in   1           asynchronous active-high reset
//  cs         in   1           command request; sampled only when rdy=1
//  read       in   1           1=read burst, 0=write burst (with cs)
//  address    in   ADDR_WIDTH  burst start word address (with cs)
//  burst_len  in   BURST_W     beats-1 (with cs)
//  be         in   NB          byte enables, sampled every write beat
//  wdata      in   DATA_WIDTH  write beat data, consumed on edges where wready=1
//  wready     out  1           write beat taken this cycle
//  rdata      out  DATA_WIDTH  read beat data, valid when rvalid=1
//  rvalid     out  1           read beat valid
//  rdy        out  1           idle, next command accepted on this edge if cs=1
//  err        out  1           one-cycle pulse: command rejected (start address >= DEPTH)
//  perr       out  1           parity error on current read beat (0 when PARITY_EN undefined)
// BEHAVIOUR
//  Reset: state IDLE, rdy=1, wready=0, rvalid=0, err=0, perr=0, rdata=0, beat counter 0; array not cleared.
//  FSM IDLE -> (cs & address<DEPTH) WRITE if !read, READ if read; (cs & address>=DEPTH) ERR -> IDLE.
//   ERR: err=1 one cycle, no array access, rdy=0 that cycle. cs ignored outside IDLE.
//  WRITE: wready=1 every cycle; beat k writes wdata to (start+k) mod DEPTH, lanes with be[i]=0 untouched;
//   after beat burst_len -> IDLE. Write of N beats: rdy low N cycles.
//  READ: issues beat k to array at (start+k) mod DEPTH each cycle; array read latency 1, so beat k appears
//   on rdata with rvalid=1 one cycle after issue. After last issue -> DRAIN (one cycle, last beat out) -> IDLE.
//   Read of N beats: first rvalid 2 cycles after accept edge, N contiguous rvalid cycles, rdy low N+1 cycles.
//  Address wrap: burst crossing DEPTH-1 continues at 0. Beat counter BURST_W bits, never overflows.
//  rdata holds last beat after rvalid drops. rdy asserted in same cycle state returns to IDLE.
//  Reset mid-burst: immediate abort, remaining beats not written/returned, rvalid/wready drop asynchronously.
// CONFIGURATION
//  RAM_BURST_PARITY_EN defined: one even-parity bit per byte lane stored alongside data (written per be);
//   on read, perr=1 with rvalid for a beat whose any lane mismatches; data still returned unchanged.
//  Undefined: no parity storage, perr tied 0.
// STRUCTURE
//  Package ram_burst_pkg: FSM state enum (IDLE, WRITE, READ, DRAIN, ERR), NB derivation function,
//   parity-per-lane function.
//  Sub-module ram_burst_core: DEPTH x (DATA_WIDTH[+NB]) array, sync write with lane mask, 1-cycle
//   registered read; controller FSM, beat counter, address incrementer stay in ram_burst_ctrl.
// TESTING
//  1 Single write addr=0x0010 data=0xA5C3 be=2'b11, then read len=0 -> rvalid 2 cycles after accept, rdata=0xA5C3.
//  2 Write burst addr=0x0100 len=3 data 1,2,3,4; read burst len=3 -> 4 contiguous rvalid, 1,2,3,4; rdy low 5 cycles.
//  3 Byte enable: mem[5]=0x1234, write 0xABCD be=2'b01 -> read 0x12CD.
//  4 Wrap: write len=2 at DEPTH-1 (0x3FFF) data 7,8,9 -> mem[0x3FFF]=7, mem[0]=8, mem[1]=9.
//  5 Error: cs at address=0x4000 (DEPTH=16384) -> err pulse 1 cycle, no rvalid/wready, rdy back next cycle.
//  6 rst asserted on beat 2 of a len=7 write -> beats 2..7 unwritten, rdy=1 and outputs at reset values at once;
//    with RAM_BURST_PARITY_EN, backdoor-flip one data bit then read -> perr=1 on that beat only.

Source files
------------

// File: rtl/ram_burst_pkg.sv
// ram_burst_pkg
//   Shared types and helpers for the burst RAM controller.
//   - state_t      : controller FSM states
//   - lanes_of()   : number of byte lanes for a given data width
//   - lane_parity(): even-parity bit for one byte lane
//   Optional feature macro used by the users of this package: RAM_BURST_PARITY_EN
package ram_burst_pkg;

  localparam int LANE_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    ERR   = 3'd4
  } state_t;

  // Byte lanes in a data word (data width is a multiple of 8).
  function automatic int lanes_of(input int data_width);
    return data_width / LANE_W;
  endfunction

  // Even parity: stored bit makes the 9-bit group have an even number of ones.
  function automatic logic lane_parity(input logic [LANE_W-1:0] lane);
    return ^lane;
  endfunction

endpackage

// File: rtl/ram_burst_core.sv
// ram_burst_core
//   Single-port DEPTH-word synchronous RAM with per-lane write mask and a
//   one-cycle registered read port.
//   Build option RAM_BURST_PARITY_EN: each word carries one even-parity bit
//   per byte lane, written together with its lane; perr reports a mismatch on
//   the registered read word. Without it perr is tied 0.
// Ports
//   clk    in   clock, posedge
//   rst    in   asynchronous active-high reset (clears read register only)
//   we     in   write strobe, lanes selected by be
//   re     in   read strobe, word appears on rdata after the next edge
//   addr   in   word index
//   be     in   byte-lane write enables
//   wdata  in   write data
//   rdata  out  registered read data, held until the next read
//   perr   out  parity mismatch on the registered read word
module ram_burst_core
  import ram_burst_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16384,
  parameter int IDX_W      = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic                    re,
  input  logic [IDX_W-1:0]        addr,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    perr
);

  localparam int NB = lanes_of(DATA_WIDTH);

`ifdef RAM_BURST_PARITY_EN
  localparam int WORD_W = DATA_WIDTH + NB;
`else
  localparam int WORD_W = DATA_WIDTH;
`endif

  logic [WORD_W-1:0] mem_array [DEPTH];
  logic [WORD_W-1:0] rword_reg;

`ifdef RAM_BURST_PARITY_EN
  logic [NB-1:0] wpar;
  logic [NB-1:0] lane_bad;

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_par
      assign wpar[gi]     = lane_parity(wdata[gi*LANE_W +: LANE_W]);
      // Recompute parity of the returned lane and compare with the stored bit.
      assign lane_bad[gi] = lane_parity(rword_reg[gi*LANE_W +: LANE_W])
                            ^ rword_reg[DATA_WIDTH + gi];
    end
  endgenerate

  assign perr = |lane_bad;
`else
  assign perr = 1'b0;
`endif

  // Array itself is never reset; only enabled lanes (and their parity) change.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem_array[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
`ifdef RAM_BURST_PARITY_EN
          mem_array[addr][DATA_WIDTH + i] <= wpar[i];
`endif
        end
      end
    end
  end

  // Registered read; holds the last beat between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rword_reg <= '0;
    end else if (re) begin
      rword_reg <= mem_array[addr];
    end
  end

  assign rdata = rword_reg[DATA_WIDTH-1:0];

endmodule

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl
//   Burst RAM with a cs/read/rdy command handshake. One command in flight;
//   rdy=1 only in IDLE, where a cs=1 command is accepted on the clock edge.
//   Write bursts take one beat per cycle (wready=1), read bursts return one
//   beat per cycle (rvalid=1) after a one-cycle array latency, with a DRAIN
//   cycle for the last beat. Bursts wrap from DEPTH-1 to 0. A start address
//   >= DEPTH is rejected with a one-cycle err pulse.
//   Build option RAM_BURST_PARITY_EN enables per-lane parity storage and the
//   perr flag (qualified by rvalid); otherwise perr is 0.
// Ports
//   clk, rst          clock (posedge) and asynchronous active-high reset
//   cs, read          command request / direction, sampled when rdy=1
//   address           burst start word address
//   burst_len         number of beats minus one
//   be                byte enables, sampled on every write beat
//   wdata             write beat data, taken on edges where wready=1
//   wready            write beat accepted this cycle
//   rdata, rvalid     read beat data and its valid flag
//   rdy               controller idle
//   err               rejected-command pulse
//   perr              parity error on the current read beat
module ram_burst_ctrl
  import ram_burst_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 16384,
  parameter int BURST_W    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cs,
  input  logic                    read,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [BURST_W-1:0]      burst_len,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic                    wready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rvalid,
  output logic                    rdy,
  output logic                    err,
  output logic                    perr
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_WIDTH is still representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);

  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     addr_reg, addr_next;
  logic [BURST_W-1:0]   len_reg, len_next;
  logic [BURST_W-1:0]   cnt_reg, cnt_next;
  logic                 rvalid_reg;

  logic                 in_range;
  logic                 last_beat;
  logic [IDX_W-1:0]     next_idx;
  logic                 mem_we;
  logic                 mem_re;
  logic                 core_perr;

  assign in_range  = ({1'b0, address} < DEPTH_EXT);
  // Counter stops at len_reg (<= 2**BURST_W-1), so it never wraps.
  assign last_beat = (cnt_reg == len_reg);
  // Non-power-of-two depths need an explicit wrap back to word 0.
  assign next_idx  = (addr_reg == LAST_IDX) ? '0 : addr_reg + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      len_reg    <= '0;
      cnt_reg    <= '0;
      rvalid_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      len_reg    <= len_next;
      cnt_reg    <= cnt_next;
      // A beat issued in READ is on rdata one cycle later.
      rvalid_reg <= (state_reg == READ);
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    len_next   = len_reg;
    cnt_next   = cnt_reg;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    wready     = 1'b0;
    rdy        = 1'b0;
    err        = 1'b0;

    case (state_reg)
      IDLE: begin
        rdy = 1'b1;
        if (cs) begin
          cnt_next = '0;
          if (!in_range) begin
            state_next = ERR;
          end else begin
            addr_next  = address[IDX_W-1:0];
            len_next   = burst_len;
            state_next = read ? READ : WRITE;
          end
        end
      end

      WRITE: begin
        wready    = 1'b1;
        mem_we    = 1'b1;
        addr_next = next_idx;
        if (last_beat) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      READ: begin
        mem_re    = 1'b1;
        addr_next = next_idx;
        if (last_beat) begin
          cnt_next   = '0;
          state_next = DRAIN;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      // Last read beat is on the bus; nothing new is issued.
      DRAIN: begin
        state_next = IDLE;
      end

      ERR: begin
        err        = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  ram_burst_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (addr_reg),
    .be    (be),
    .wdata (wdata),
    .rdata (rdata),
    .perr  (core_perr)
  );

  assign rvalid = rvalid_reg;
  assign perr   = rvalid_reg & core_perr;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
`timescale 1ns/1ps
module tb_ram_burst_ctrl;

  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int DEPTH = 16384;
  localparam int BW    = 4;
  localparam int NB    = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cs = 1'b0;
  logic          read = 1'b0;
  logic [AW-1:0] address = '0;
  logic [BW-1:0] burst_len = '0;
  logic [NB-1:0] be = '0;
  logic [DW-1:0] wdata = '0;
  logic          wready;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          rdy;
  logic          err;
  logic          perr;

  always #5 clk = ~clk;

  ram_burst_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .BURST_W    (BW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cs        (cs),
    .read      (read),
    .address   (address),
    .burst_len (burst_len),
    .be        (be),
    .wdata     (wdata),
    .wready    (wready),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .rdy       (rdy),
    .err       (err),
    .perr      (perr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference memory: word contents plus which byte lanes are known.
  logic [DW-1:0] ref_mem [DEPTH];
  logic [NB-1:0] ref_vld [DEPTH];
  int            bad_addr = -1;

  logic [DW-1:0] wbuf  [16];
  logic [NB-1:0] bebuf [16];
  logic [DW-1:0] rbuf  [16];

  typedef struct {
    logic          is_rd;
    logic [AW-1:0] addr;
    logic [NB-1:0] be;
    logic [DW-1:0] data;
    logic [DW-1:0] exp;
  } vec_t;

  typedef struct {
    int start;
    int len;
  } region_t;

  vec_t    tbl [8];
  region_t written [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] lane_mask(input logic [NB-1:0] v);
    logic [DW-1:0] m;
    m = '0;
    for (int i = 0; i < NB; i++) m[i*8 +: 8] = {8{v[i]}};
    return m;
  endfunction

  function automatic int wrap(input int a);
    return a % DEPTH;
  endfunction

  task automatic model_write(input int a, input logic [DW-1:0] d, input logic [NB-1:0] b);
    for (int i = 0; i < NB; i++) begin
      if (b[i]) begin
        ref_mem[a][i*8 +: 8] = d[i*8 +: 8];
        ref_vld[a][i] = 1'b1;
      end
    end
  endtask

  // Compare rdata with the model on the lanes the model knows.
  task automatic check_beat(input string name, input int a);
    logic [DW-1:0] m;
    m = lane_mask(ref_vld[a]);
    if (m != '0) check($sformatf("%s@%04h", name, a), rdata & m, ref_mem[a] & m);
  endtask

  task automatic do_write(input int addr, input int len);
    int a;
    $display("WR addr=%04h len=%0d", addr, len);
    check("wr_rdy_idle", rdy, 1);
    cs = 1'b1; read = 1'b0; address = AW'(addr); burst_len = BW'(len);
    @(posedge clk); #1;
    for (int k = 0; k <= len; k++) begin
      // Commands during a burst must be ignored.
      cs = 1'($urandom_range(0, 1)); read = 1'($urandom_range(0, 1));
      address = AW'($urandom); burst_len = BW'($urandom);
      wdata = wbuf[k]; be = bebuf[k];
      check("wr_wready", wready, 1);
      check("wr_rdy_busy", rdy, 0);
      a = wrap(addr + k);
      model_write(a, wbuf[k], bebuf[k]);
      @(posedge clk); #1;
    end
    check("wr_done_wready", wready, 0);
    check("wr_done_rdy", rdy, 1);
    cs = 1'b0; read = 1'b0;
  endtask

  task automatic do_read(input int addr, input int len);
    int a;
    $display("RD addr=%04h len=%0d", addr, len);
    check("rd_rdy_idle", rdy, 1);
    cs = 1'b1; read = 1'b1; address = AW'(addr); burst_len = BW'(len);
    @(posedge clk); #1;
    cs = 1'b0;
    check("rd_issue_rvalid", rvalid, 0);
    check("rd_issue_rdy", rdy, 0);
    for (int k = 0; k <= len; k++) begin
      @(posedge clk); #1;
      cs = 1'($urandom_range(0, 1)); address = AW'($urandom);
      a = wrap(addr + k);
      check("rd_rvalid", rvalid, 1);
      check("rd_rdy_busy", rdy, 0);
      check("rd_wready", wready, 0);
      check("rd_perr", perr, 32'(a == bad_addr));
      check_beat("rd_data", a);
      rbuf[k] = rdata;
    end
    @(posedge clk); #1;
    check("rd_done_rvalid", rvalid, 0);
    check("rd_done_rdy", rdy, 1);
    check("rd_done_perr", perr, 0);
    check_beat("rd_hold", wrap(addr + len));
    cs = 1'b0; read = 1'b0;
  endtask

  task automatic do_err(input int addr);
    $display("ERR addr=%04h", addr);
    check("err_rdy_idle", rdy, 1);
    cs = 1'b1; read = 1'($urandom_range(0, 1)); address = AW'(addr); burst_len = BW'($urandom);
    @(posedge clk); #1;
    cs = 1'b0;
    check("err_pulse", err, 1);
    check("err_rdy", rdy, 0);
    check("err_rvalid", rvalid, 0);
    check("err_wready", wready, 0);
    @(posedge clk); #1;
    check("err_clear", err, 0);
    check("err_rdy_back", rdy, 1);
    check("err_rvalid2", rvalid, 0);
    check("err_wready2", wready, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int r, start, len;
    region_t rg;

    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = '0;
      ref_vld[i] = '0;
    end

    // Reset state
    #12;
    $display("RESET");
    check("rst_rdy", rdy, 1);
    check("rst_wready", wready, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_err", err, 0);
    check("rst_perr", perr, 0);
    check("rst_rdata", rdata, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Single-beat vectors: plain write/read and byte-enable merges.
    tbl[0] = '{1'b0, 16'h0010, 2'b11, 16'hA5C3, 16'h0000};
    tbl[1] = '{1'b1, 16'h0010, 2'b00, 16'h0000, 16'hA5C3};
    tbl[2] = '{1'b0, 16'h0005, 2'b11, 16'h1234, 16'h0000};
    tbl[3] = '{1'b0, 16'h0005, 2'b01, 16'hABCD, 16'h0000};
    tbl[4] = '{1'b1, 16'h0005, 2'b00, 16'h0000, 16'h12CD};
    tbl[5] = '{1'b0, 16'h0006, 2'b11, 16'hFFFF, 16'h0000};
    tbl[6] = '{1'b0, 16'h0006, 2'b10, 16'h0000, 16'h0000};
    tbl[7] = '{1'b1, 16'h0006, 2'b00, 16'h0000, 16'h00FF};
    for (int i = 0; i < 8; i++) begin
      if (!tbl[i].is_rd) begin
        wbuf[0] = tbl[i].data; bebuf[0] = tbl[i].be;
        do_write(int'(tbl[i].addr), 0);
      end else begin
        do_read(int'(tbl[i].addr), 0);
        check($sformatf("tbl_rdata[%0d]", i), rbuf[0], tbl[i].exp);
      end
    end

    // Four-beat burst
    for (int k = 0; k < 4; k++) begin wbuf[k] = DW'(k + 1); bebuf[k] = 2'b11; end
    do_write(16'h0100, 3);
    do_read(16'h0100, 3);
    for (int k = 0; k < 4; k++) check($sformatf("burst_beat%0d", k), rbuf[k], k + 1);

    // Wrap across DEPTH-1
    wbuf[0] = 16'd7; wbuf[1] = 16'd8; wbuf[2] = 16'd9;
    for (int k = 0; k < 3; k++) bebuf[k] = 2'b11;
    do_write(DEPTH - 1, 2);
    do_read(0, 1);
    check("wrap_mem0", rbuf[0], 8);
    check("wrap_mem1", rbuf[1], 9);
    do_read(DEPTH - 1, 2);
    check("wrap_last", rbuf[0], 7);
    check("wrap_first", rbuf[1], 8);

    // Rejected commands
    do_err(16'h4000);
    do_err(16'hFFFF);

    // Maximum-length burst
    for (int k = 0; k < 16; k++) begin wbuf[k] = DW'(16'hC000 + k); bebuf[k] = 2'b11; end
    do_write(16'h0400, 15);
    do_read(16'h0400, 15);
    check("maxlen_last", rbuf[15], 16'hC00F);

    // Reset in the middle of a write burst
    for (int k = 0; k < 8; k++) begin wbuf[k] = DW'(16'h1110 + k); bebuf[k] = 2'b11; end
    do_write(16'h0200, 7);
    $display("WR-ABORT addr=0200 len=7");
    cs = 1'b1; read = 1'b0; address = 16'h0200; burst_len = 4'd7;
    @(posedge clk); #1;
    cs = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wdata = DW'(16'hBEE0 + k); be = 2'b11;
      check("abort_wready", wready, 1);
      model_write(16'h0200 + k, DW'(16'hBEE0 + k), 2'b11);
      @(posedge clk); #1;
    end
    wdata = 16'hBEE2; be = 2'b11;
    #1 rst = 1'b1;
    #1;
    check("abort_rdy", rdy, 1);
    check("abort_wready0", wready, 0);
    check("abort_rvalid", rvalid, 0);
    check("abort_err", err, 0);
    check("abort_perr", perr, 0);
    check("abort_rdata", rdata, 0);
    @(posedge clk); @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_rdy", rdy, 1);
    do_read(16'h0200, 7);
    check("abort_beat0", rbuf[0], 16'hBEE0);
    check("abort_beat1", rbuf[1], 16'hBEE1);
    check("abort_beat2", rbuf[2], 16'h1112);
    check("abort_beat7", rbuf[7], 16'h1117);

    // Randomized traffic against the reference model
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        do_err(DEPTH + $urandom_range(0, (1 << AW) - 1 - DEPTH));
      end else if (r <= 5 || written.size() == 0) begin
        start = ($urandom_range(0, 3) == 0) ? DEPTH - 1 - $urandom_range(0, 15)
                                            : $urandom_range(0, DEPTH - 1);
        len = $urandom_range(0, 15);
        for (int k = 0; k <= len; k++) begin
          wbuf[k] = DW'($urandom); bebuf[k] = NB'($urandom_range(0, 3));
        end
        do_write(start, len);
        rg.start = start; rg.len = len;
        written.push_back(rg);
      end else begin
        rg = written[$urandom_range(0, written.size() - 1)];
        do_read(rg.start, $urandom_range(0, rg.len));
      end
    end

`ifdef RAM_BURST_PARITY_EN
    // Corrupt one stored data bit; only that beat may flag perr.
    wbuf[0] = 16'h0F0F; wbuf[1] = 16'h3C3C; bebuf[0] = 2'b11; bebuf[1] = 2'b11;
    do_write(16'h0300, 1);
    dut.u_core.mem_array['h300][0] = ~dut.u_core.mem_array['h300][0];
    ref_mem[16'h0300][0] = ~ref_mem[16'h0300][0];
    bad_addr = 16'h0300;
    do_read(16'h0300, 1);
    check("par_data0", rbuf[0], 16'h0F0E);
    check("par_data1", rbuf[1], 16'h3C3C);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
